// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and digit check for the serial BCD subtractor.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  localparam int BCD_W = 4;
  localparam int BCD_MAX = 9;
  typedef logic [BCD_W-1:0] digit_t;
  function automatic logic is_bcd(digit_t d);
    return d <= digit_t'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_serial_sub_digit.sv
// bcd_digit_sub: one-digit BCD subtract with borrow in/out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  digit_t a,
  input  digit_t b,
  input  logic   bin,
  output digit_t d,
  output logic   bout
);
  logic [4:0] t;
  assign t = {1'b0, a} - {1'b0, b} - {4'b0, bin};
  assign bout = {1'b0, a} < {1'b0, b} + {4'b0, bin};
  assign d = bout ? digit_t'(t + 5'd10) : t[3:0];
endmodule

// File: rtl/bcd_serial_sub.sv
// bcd_serial_sub: digit-serial BCD subtractor A-B, LSD first, start/busy/done handshake.
// Define BCD_SUB_SIGN_EN to add the FIX phase that turns negative results into sign-magnitude.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W*DIGITS-1:0] diff,
  output logic                  neg,
  output logic                  err
);
  localparam int W = BCD_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef BCD_SUB_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif
  state_t state, next;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic borrow, bad, last, bout;
  digit_t op_a, op_b, d;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | !is_bcd(a[i*BCD_W +: BCD_W]) | !is_bcd(b[i*BCD_W +: BCD_W]);
  end
  assign last = idx == IW'(DIGITS - 1);
  // diff doubles as the result shift register, so after SUB digit 0 of the raw result sits at the bottom
  assign op_a = state == FIX ? '0 : a_r[BCD_W-1:0];
  assign op_b = state == FIX ? diff[BCD_W-1:0] : b_r[BCD_W-1:0];
  bcd_digit_sub u_sub (.a(op_a), .b(op_b), .bin(borrow), .d(d), .bout(bout));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = start ? (bad ? DONE : SUB) : IDLE;
      SUB:  next = last ? ((bout && SIGN_EN) ? FIX : DONE) : SUB;
      FIX:  next = last ? DONE : FIX;
      DONE: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      neg <= 1'b0;
      err <= 1'b0;
      borrow <= 1'b0;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          busy <= 1'b1;
          err <= bad;
          borrow <= 1'b0;
          idx <= '0;
        end
        SUB, FIX: begin
          diff <= (W'(d) << (W - BCD_W)) | (diff >> BCD_W);
          a_r <= a_r >> BCD_W;
          b_r <= b_r >> BCD_W;
          borrow <= last ? 1'b0 : bout;
          idx <= last ? '0 : idx + 1'b1;
          if (state == SUB && last) neg <= bout;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
